// File: rtl/lane_deserializer_if.sv
// Lane receive bundle: serial bit in, assembled 32-bit word plus strobe and lock flag out.
// No backpressure; the deserializer owns the outputs, the upstream source owns data_in.
interface lane_deserializer_if;
  logic        data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;

  modport master (output data_in, input data_out, input valid_out, input active);
  modport slave  (input data_in, output data_out, output valid_out, output active);
endinterface

// File: rtl/lane_deserializer.sv
// Serial-to-parallel lane receiver: comma-aligned lock, then 32-bit words MSB first.
// Word strobe on the edge sampling its last bit; no backpressure, commas are idle.
module lane_deserializer #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic               clk_32f,
  input  logic               reset_L,
  lane_deserializer_if.slave lane
);

  typedef enum logic [1:0] {INIT, ALIGN, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  state_t      state_q;
  logic [6:0]  sr_q;
  logic [2:0]  bit_cnt_q;
  logic [3:0]  comma_cnt_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  b0_q, b1_q, b2_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        active_q;

  logic [7:0]  cur_byte;
  logic        boundary;
  logic        is_comma;

  assign cur_byte = {sr_q, lane.data_in};
  assign boundary = (bit_cnt_q == 3'd7);
  assign is_comma = (cur_byte == COMMA);

  assign lane.data_out  = data_q;
  assign lane.valid_out = valid_q;
  assign lane.active    = active_q;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= INIT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      byte_idx_q  <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      sr_q      <= cur_byte[6:0];
      bit_cnt_q <= bit_cnt_q + 3'd1;
      valid_q   <= 1'b0;
      case (state_q)
        // Hunting: any bit position may start a comma, which also fixes byte phase.
        INIT: begin
          if (is_comma) begin
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 4'd1;
            if (LOCK_CNT == 4'd1) begin
              state_q  <= LOCKED;
              active_q <= 1'b1;
            end else begin
              state_q <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (boundary) begin
            if (is_comma) begin
              comma_cnt_q <= comma_cnt_q + 4'd1;
              if (comma_cnt_q + 4'd1 == LOCK_CNT) begin
                state_q  <= LOCKED;
                active_q <= 1'b1;
              end
            end else begin
              state_q     <= INIT;
              comma_cnt_q <= 4'd0;
            end
          end
        end
        // Byte phase is frozen here; only reset can drop lock.
        LOCKED: begin
          if (boundary) begin
            if (is_comma) begin
              byte_idx_q <= 2'd0;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              case (byte_idx_q)
                2'd0: b0_q <= cur_byte;
                2'd1: b1_q <= cur_byte;
                2'd2: b2_q <= cur_byte;
                2'd3: begin
                  data_q  <= {b0_q, b1_q, b2_q, cur_byte};
                  valid_q <= 1'b1;
                end
              endcase
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_deserializer.sv
// Bench for lane_deserializer: directed vector table, hand sequences and random streams vs a stream model.
module tb_lane_deserializer;

  localparam logic [7:0] BC = 8'hBC;
  localparam int LC = 4;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk_32f = ~clk_32f;

  lane_deserializer_if lif();

  lane_deserializer #(.COMMA(BC), .LOCK_COUNT(LC)) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .lane    (lif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          edge_n;
  int          rise_edge;
  int          strobes;
  int          strobe_edge;
  logic [31:0] cap_data;

  logic        stim_q[$];
  logic [33:0] exp_q[$];

  typedef struct {
    int          jn;
    logic [7:0]  jb;
    int          pn;
    logic [63:0] pre;
    logic [31:0] word;
    int          exp_rise;
    int          exp_strobes;
    int          exp_sedge;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    lif.data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #2;
    reset_L = 1'b1;
    edge_n = 0; rise_edge = -1; strobes = 0; strobe_edge = -1; cap_data = '0;
  endtask

  task automatic step(input logic b);
    lif.data_in = b;
    @(posedge clk_32f);
    #1;
    if (lif.active && rise_edge < 0) rise_edge = edge_n;
    if (lif.valid_out) begin
      strobes++;
      strobe_edge = edge_n;
      cap_data = lif.data_out;
    end
    edge_n++;
  endtask

  task automatic send_byte(input logic [7:0] by);
    for (int k = 7; k >= 0; k--) step(by[k]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 31; k >= 0; k--) step(w[k]);
  endtask

  // Byte ending at stream position i; bits before the stream start read as 0.
  function automatic logic [7:0] win(input int i);
    logic [7:0] w;
    int idx;
    w = 8'h00;
    for (int b = 0; b < 8; b++) begin
      idx = i - 7 + b;
      w = {w[6:0], (idx >= 0) ? stim_q[idx] : 1'b0};
    end
    return w;
  endfunction

  // Whole-stream reference: locate the lock point, then slice aligned bytes into words.
  function automatic void build_model();
    int n, lock, i, j, run;
    logic [7:0]  by;
    logic [7:0]  pend[$];
    logic        vflag[$];
    logic [31:0] wdat[$];
    logic [31:0] last;
    n = stim_q.size();
    lock = -1;
    i = 0;
    while (i < n && lock < 0) begin
      if (win(i) == BC) begin
        run = 1;
        j = i;
        if (run == LC) lock = j;
        while (lock < 0) begin
          j += 8;
          if (j >= n) break;
          if (win(j) == BC) begin
            run++;
            if (run == LC) lock = j;
          end else break;
        end
        if (lock < 0) i = j + 1;
      end else begin
        i++;
      end
    end
    vflag.delete(); wdat.delete(); pend.delete();
    for (int e = 0; e < n; e++) begin vflag.push_back(1'b0); wdat.push_back(32'h0); end
    if (lock >= 0) begin
      for (int k = lock + 8; k < n; k += 8) begin
        by = win(k);
        if (by == BC) pend.delete();
        else begin
          pend.push_back(by);
          if (pend.size() == 4) begin
            vflag[k] = 1'b1;
            wdat[k] = {pend[0], pend[1], pend[2], pend[3]};
            pend.delete();
          end
        end
      end
    end
    exp_q.delete();
    last = 32'h0;
    for (int e = 0; e < n; e++) begin
      if (vflag[e]) last = wdat[e];
      exp_q.push_back({(lock >= 0 && e >= lock), vflag[e], last});
    end
  endfunction

  task automatic push_byte(input logic [7:0] by);
    for (int k = 7; k >= 0; k--) stim_q.push_back(by[k]);
  endtask

  initial begin
    logic [7:0] rb;
    int jn;

    vt[0] = '{0, 8'h00, 4, 64'hBCBCBCBC_00000000, 32'hFFFF_FFFF, 31, 1, 63, 32'hFFFF_FFFF};
    vt[1] = '{3, 8'h05, 4, 64'hBCBCBCBC_00000000, 32'hEEEE_EEEE, 34, 1, 66, 32'hEEEE_EEEE};
    vt[2] = '{0, 8'h00, 7, 64'hBCBC00BC_BCBCBC00, 32'hDDDD_DDDD, 55, 1, 87, 32'hDDDD_DDDD};
    vt[3] = '{0, 8'h00, 7, 64'hBCBCBCBC_EEEEBC00, 32'hDDDD_DDDD, 31, 1, 87, 32'hDDDD_DDDD};
    vt[4] = '{0, 8'h00, 4, 64'hBCBCBCBC_00000000, 32'h0BC0_0000, 31, 1, 63, 32'h0BC0_0000};
    vt[5] = '{0, 8'h00, 3, 64'hBCBCBC00_00000000, 32'hCCCC_CCCC, -1, 0, -1, 32'h0000_0000};

    lif.data_in = 1'b0;
    #3;
    check("reset_outputs", {30'h0, lif.active, lif.valid_out, lif.data_out}, 64'h0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int k = vt[v].jn - 1; k >= 0; k--) step(vt[v].jb[k]);
      for (int k = 0; k < vt[v].pn; k++) send_byte(vt[v].pre[63 - 8*k -: 8]);
      send_word(vt[v].word);
      send_byte(BC);
      send_byte(BC);
      check($sformatf("vec%0d_rise_edge", v), rise_edge, vt[v].exp_rise);
      check($sformatf("vec%0d_strobes", v), strobes, vt[v].exp_strobes);
      check($sformatf("vec%0d_strobe_edge", v), strobe_edge, vt[v].exp_sedge);
      check($sformatf("vec%0d_data", v), lif.data_out, vt[v].exp_data);
    end

    // Back-to-back words, then async reset two bytes into the next word.
    do_reset();
    repeat (4) send_byte(BC);
    send_word(32'hCCCC_CCCC);
    check("b2b_first_edge", strobe_edge, 63);
    check("b2b_first_data", cap_data, 32'hCCCC_CCCC);
    send_word(32'hFFFF_FFFF);
    check("b2b_second_edge", strobe_edge, 95);
    check("b2b_second_data", cap_data, 32'hFFFF_FFFF);
    check("b2b_strobes", strobes, 2);
    send_byte(8'hAA);
    send_byte(8'h55);
    #2;
    reset_L = 1'b0;
    #1;
    check("midreset_outputs", {30'h0, lif.active, lif.valid_out, lif.data_out}, 64'h0);
    do_reset();
    send_byte(BC); send_byte(BC); send_byte(BC);
    check("relock_not_early", lif.active, 1'b0);
    send_byte(BC);
    send_word(32'hCCCC_CCCC);
    check("relock_rise_edge", rise_edge, 31);
    check("relock_strobe_edge", strobe_edge, 63);
    check("relock_data", lif.data_out, 32'hCCCC_CCCC);

    // Random streams against the whole-stream model, compared every edge.
    for (int t = 0; t < 20; t++) begin
      stim_q.delete();
      jn = $urandom_range(0, 7);
      for (int k = 0; k < jn; k++) stim_q.push_back(1'($urandom_range(0, 1)));
      for (int p = 0; p < 6; p++) begin
        rb = ($urandom_range(0, 7) != 0) ? BC : 8'($urandom_range(0, 255));
        push_byte(rb);
      end
      for (int p = 0; p < 40; p++) begin
        rb = ($urandom_range(0, 4) == 0) ? BC : 8'($urandom_range(0, 255));
        push_byte(rb);
      end
      build_model();
      do_reset();
      for (int e = 0; e < stim_q.size(); e++) begin
        step(stim_q[e]);
        check($sformatf("rand%0d_edge%0d", t, e),
              {30'h0, lif.active, lif.valid_out, lif.data_out}, {30'h0, exp_q[e]});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
